// File: rtl/accum_output_ctrl.sv
// Multi-pass accumulator output stage: clip, partial-sum feedback, 4-deep FIFO.
// Define ACCUM_OUTPUT_RELU_EN to rectify negative values pushed to the FIFO.
module accum_output_ctrl (
  input  logic               clk,
  input  logic               reset,
  input  logic [13:0]        adder_sum,
  input  logic               sum_valid,
  output logic               sum_ready,
  input  logic [3:0]         num_pass,
  output logic signed [12:0] pre_output,
  output logic signed [12:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         sat_cnt
);

  logic [12:0] clip_val;
  logic        clip_sat;
  logic [12:0] push_val;
  logic [3:0]  n_sel;
  logic        last;
  logic        full;
  logic        accept;
  logic        push;
  logic        pop;

  logic [3:0]  n_q, n_d;
  logic [3:0]  pass_cnt_q, pass_cnt_d;
  logic [12:0] pre_q, pre_d;
  logic [7:0]  sat_q, sat_d;

  logic [12:0] mem_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  cnt_q, cnt_d;

  always_comb begin
    clip_val = adder_sum[12:0];
    clip_sat = 1'b0;
    unique case (adder_sum[13:12])
      2'b01: begin
        clip_val = 13'h0FFF;
        clip_sat = 1'b1;
      end
      2'b10: begin
        clip_val = 13'h1000;
        clip_sat = 1'b1;
      end
      default: begin
        clip_val = adder_sum[12:0];
        clip_sat = 1'b0;
      end
    endcase
  end

`ifdef ACCUM_OUTPUT_RELU_EN
  assign push_val = clip_val[12] ? 13'h0000 : clip_val;
`else
  assign push_val = clip_val;
`endif

  // At group start the live num_pass decides whether this pass is final.
  always_comb begin
    n_sel = n_q;
    if (pass_cnt_q == 4'd0) begin
      n_sel = (num_pass == 4'd0) ? 4'd1 : num_pass;
    end
  end

  assign last      = (pass_cnt_q == n_sel - 4'd1);
  assign full      = (cnt_q == 3'd4);
  assign sum_ready = !(full && last);
  assign accept    = sum_valid && sum_ready;
  assign push      = accept && last;
  assign out_valid = (cnt_q != 3'd0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    n_d        = n_q;
    pass_cnt_d = pass_cnt_q;
    pre_d      = pre_q;
    if (accept) begin
      if (pass_cnt_q == 4'd0) begin
        n_d = n_sel;
      end
      if (last) begin
        pass_cnt_d = 4'd0;
        pre_d      = 13'h0000;
      end else begin
        pass_cnt_d = pass_cnt_q + 4'd1;
        pre_d      = clip_val;
      end
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (accept && clip_sat && (sat_q != 8'hFF)) begin
      sat_d = sat_q + 8'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q        <= 4'd1;
      pass_cnt_q <= 4'd0;
      pre_q      <= 13'h0000;
      sat_q      <= 8'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      cnt_q      <= 3'd0;
    end else begin
      n_q        <= n_d;
      pass_cnt_q <= pass_cnt_d;
      pre_q      <= pre_d;
      sat_q      <= sat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 13'h0000;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_val;
    end
  end

  assign pre_output = pre_q;
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : 13'h0000;
  assign sat_cnt    = sat_q;

endmodule

// File: tb/tb_accum_output_ctrl.sv
// Scoreboard bench for accum_output_ctrl.
// Expected FIFO values are queued on acceptance and matched on pop.
module tb_accum_output_ctrl;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [13:0]        adder_sum = 14'h0;
  logic               sum_valid = 1'b0;
  logic               sum_ready;
  logic [3:0]         num_pass = 4'd1;
  logic signed [12:0] pre_output;
  logic signed [12:0] out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [7:0]         sat_cnt;

  int total = 0;
  int bad = 0;

  logic [12:0] sb_q[$];
  logic [12:0] mon_exp;
  int          m_cnt = 0;
  int          m_n = 1;
  int          m_sat = 0;
  logic [12:0] m_pre = 13'h0;

  accum_output_ctrl dut (
    .clk(clk),
    .reset(reset),
    .adder_sum(adder_sum),
    .sum_valid(sum_valid),
    .sum_ready(sum_ready),
    .num_pass(num_pass),
    .pre_output(pre_output),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("spurious_pop", 16'd1, 16'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("out_data", {3'b0, out_data}, {3'b0, mon_exp});
      end
    end
  end

  task automatic model_accept(input logic [13:0] s, input logic [3:0] np);
    logic [12:0] c;
    logic        st;
    st = (s[13:12] == 2'b01) || (s[13:12] == 2'b10);
    if (s[13:12] == 2'b01) c = 13'h0FFF;
    else if (s[13:12] == 2'b10) c = 13'h1000;
    else c = s[12:0];
    if (m_cnt == 0) m_n = (np == 4'd0) ? 1 : int'(np);
    if (st && m_sat != 255) m_sat++;
    if (m_cnt == m_n - 1) begin
`ifdef ACCUM_OUTPUT_RELU_EN
      if (c[12]) c = 13'h0;
`endif
      sb_q.push_back(c);
      m_pre = 13'h0;
      m_cnt = 0;
    end else begin
      m_pre = c;
      m_cnt++;
    end
  endtask

  task automatic send(input logic [13:0] s, input logic [3:0] np);
    int w;
    w = 0;
    adder_sum = s;
    num_pass = np;
    sum_valid = 1'b1;
    @(negedge clk);
    while (!sum_ready && w < 50) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      w++;
    end
    if (!sum_ready) chk("ready_timeout", 16'd0, 16'd1);
    else model_accept(s, np);
    @(posedge clk);
    #1;
    sum_valid = 1'b0;
    chk("pre_output", {3'b0, pre_output}, {3'b0, m_pre});
    chk("sat_cnt", {8'b0, sat_cnt}, m_sat[15:0]);
  endtask

  task automatic drain();
    int w;
    w = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_q", sb_q.size(), 16'd0);
    chk("drain_valid", {15'b0, out_valid}, 16'd0);
    chk("drain_data", {3'b0, out_data}, 16'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pre", {3'b0, pre_output}, 16'd0);
    chk("rst_valid", {15'b0, out_valid}, 16'd0);
    chk("rst_data", {3'b0, out_data}, 16'd0);
    chk("rst_sat", {8'b0, sat_cnt}, 16'd0);
    chk("rst_ready", {15'b0, sum_ready}, 16'd1);
    reset = 1'b0;

    // N=1 single pass, latency into empty FIFO
    out_ready = 1'b0;
    send(14'h0040, 4'd1);
    chk("n1_valid", {15'b0, out_valid}, 16'd1);
    chk("n1_data", {3'b0, out_data}, 16'h0040);
    drain();

    // N=3 with saturating final pass
    send(14'h0010, 4'd3);
    chk("n3_pre0", {3'b0, pre_output}, 16'h0010);
    send(14'h0FF0, 4'd3);
    chk("n3_pre1", {3'b0, pre_output}, 16'h0FF0);
    send(14'h1234, 4'd3);
    chk("n3_sat", {8'b0, sat_cnt}, 16'd1);
    chk("n3_pre2", {3'b0, pre_output}, 16'd0);
    drain();

    // negative saturation, N=0 treated as 1
    out_ready = 1'b0;
    send(14'h2005, 4'd0);
`ifdef ACCUM_OUTPUT_RELU_EN
    chk("neg_sat", {3'b0, out_data}, 16'h0000);
`else
    chk("neg_sat", {3'b0, out_data}, 16'h1000);
`endif
    drain();

    // fill FIFO, fifth final pass stalls until a pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(14'h0100 + 14'(i), 4'd1);
    chk("full_valid", {15'b0, out_valid}, 16'd1);
    adder_sum = 14'h0104;
    num_pass = 4'd1;
    sum_valid = 1'b1;
    @(negedge clk);
    chk("full_ready", {15'b0, sum_ready}, 16'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_same_ready", {15'b0, sum_ready}, 16'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_ready", {15'b0, sum_ready}, 16'd1);
    model_accept(14'h0104, 4'd1);
    @(posedge clk);
    #1;
    sum_valid = 1'b0;
    drain();

    // reset mid-group discards partial sum
    send(14'h0011, 4'd4);
    send(14'h0022, 4'd4);
    chk("mid_pre", {3'b0, pre_output}, 16'h0022);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cnt = 0;
    m_n = 1;
    m_sat = 0;
    m_pre = 13'h0;
    chk("rst2_pre", {3'b0, pre_output}, 16'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(14'h0030 + 14'(i), 4'd4);
    chk("rst2_no_out", {15'b0, out_valid}, 16'd0);
    send(14'h0033, 4'd4);
    chk("rst2_out", {15'b0, out_valid}, 16'd1);
    chk("rst2_data", {3'b0, out_data}, 16'h0033);
    drain();

    // num_pass change mid-group
    out_ready = 1'b0;
    send(14'h0001, 4'd3);
    send(14'h0002, 4'd2);
    chk("np_hold", {15'b0, out_valid}, 16'd0);
    send(14'h0003, 4'd2);
    chk("np_g1", {15'b0, out_valid}, 16'd1);
    send(14'h0004, 4'd2);
    send(14'h0005, 4'd2);
    drain();

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(14'($urandom), 4'($urandom_range(0, 5)));
    end
    drain();

    // sat_cnt saturation at 255
    for (int i = 0; i < 260; i++) send(14'h1000, 4'd1);
    chk("sat_hold", {8'b0, sat_cnt}, 16'd255);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_output_ctrl.md
ACCUM_OUTPUT_CTRL -- requirements
Module: accum_output_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: clk input 1 (rising edge), and reset input 1, synchronous, active-high.
REQ-002 Port adder_sum SHALL be an input, 14 bits wide: the final adder result; bits [13:12] are the overflow indicator and bits [12:0] are the signed value.
REQ-003 Port sum_valid SHALL be an input, 1 bit wide, asserted when adder_sum holds a valid pass result.
REQ-004 Port sum_ready SHALL be an output, 1 bit wide; a pass is accepted when sum_valid and sum_ready are both high at a rising edge.
REQ-005 Port num_pass SHALL be an input, 4 bits wide, giving the number of accumulation passes per output pixel.
REQ-006 Port pre_output SHALL be an output, 13 bits, signed: the registered partial sum fed back to addertree_stage2.
REQ-007 Port out_data SHALL be an output, 13 bits, signed: the FIFO head.
REQ-008 Port out_valid SHALL be an output, 1 bit: the FIFO is non-empty.
REQ-009 Port out_ready SHALL be an input, 1 bit: the downstream consumer is ready.
REQ-010 Port sat_cnt SHALL be an output, 8 bits: the count of clipped passes.

Function
REQ-011 The clip rule SHALL be as follows: adder_sum[13:12]=01 gives +4095 (0x0FFF); adder_sum[13:12]=10 gives -4096 (0x1000); any other value gives adder_sum[12:0].
REQ-012 A pass counter pass_cnt (4 bits, 0..14) SHALL track position within the current group.
REQ-013 The effective pass count N SHALL be sampled from num_pass only when a sum is accepted with pass_cnt=0, and held until the group ends; num_pass=0 SHALL be treated as N=1.
REQ-014 An accepted non-final pass (pass_cnt<N-1) SHALL set pre_output to the clipped value and increment pass_cnt, both on the same edge.
REQ-015 An accepted final pass (pass_cnt=N-1) SHALL push the clipped value into the FIFO, set pre_output to 0, and set pass_cnt to 0.
REQ-016 With N=1, every accepted pass SHALL be final, and pre_output SHALL remain 0.
REQ-017 The output FIFO SHALL be 4 entries deep, use wrap-around pointers, and hold a 3-bit occupancy count.
REQ-018 sum_ready SHALL be 0 when the FIFO holds 4 entries and pass_cnt=N-1; otherwise sum_ready SHALL be 1. Non-final passes are never stalled.
REQ-019 sum_valid while sum_ready=0 SHALL be ignored; upstream holds its data.
REQ-020 A pop SHALL occur on any edge where out_valid and out_ready are both high; out_data advances on the next cycle.
REQ-021 A simultaneous push and pop on a non-empty FIFO SHALL leave the occupancy unchanged.
REQ-022 When the FIFO is full, a same-cycle pop SHALL NOT enable a push; sum_ready is recomputed from the registered occupancy.
REQ-023 Latency: a value accepted as a final pass on edge k SHALL be visible with out_valid=1 after edge k if the FIFO was empty.
REQ-024 sat_cnt SHALL increment on each accepted pass whose clip rule saturated, and SHALL hold at 255.
REQ-025 out_data SHALL read 0 when out_valid=0.

Reset
REQ-026 Reset SHALL set the following on the next rising edge: pre_output=0, pass_cnt=0, FIFO empty, out_valid=0, out_data=0, sat_cnt=0, sum_ready=1, N=1.
REQ-027 A reset asserted mid-group SHALL discard the partial sum; the first pass after reset SHALL be treated as pass 0.
REQ-028 Reset SHALL take priority over a simultaneous accept or pop.

Configuration
REQ-029 The macro ACCUM_OUTPUT_RELU_EN SHALL select output ReLU: when defined, negative clipped values are written to the FIFO as 0 on final passes only, and pre_output feedback is never rectified; when undefined, values pass unchanged.

Verification
REQ-030 Scenario: N=1, adder_sum=0x0040, no stall -> out_data=0x0040 one cycle later, pre_output=0 throughout.
REQ-031 Scenario: N=3, passes 0x0010, 0x0FF0, 0x1234 (bits[13:12]=01) -> pre_output=0x0010, then 0x0FF0, then final push of 0x0FFF, sat_cnt=1, pre_output=0.
REQ-032 Scenario: N=1, adder_sum=0x2005 (bits[13:12]=10) -> push 0x1000 (-4096); with ACCUM_OUTPUT_RELU_EN defined -> push 0x0000.
REQ-033 Scenario: out_ready=0, 5 final passes offered -> 4 accepted, sum_ready=0 on the fifth; after one pop, sum_ready=1 on the next cycle and output order is preserved.
REQ-034 Scenario: N=4, reset after 2 passes -> pre_output=0, pass_cnt=0; the next group produces an output after exactly 4 passes.
REQ-035 Scenario: num_pass changes from 3 to 2 mid-group -> the current group still uses 3 passes; the next group uses 2.
